// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 512 x 32 main-memory RAM.
// Port 0 is instruction fetch, port 1 is load/store; one access is in flight at a time.
module ram_port_arbiter #(
    parameter int AW            = 9,
    parameter int DW            = 32,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic          clk,
    input  logic          clr,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,

    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q,

    output logic          busy,
    output logic          grant
);

    // A zero-cycle access cannot exist, so it runs as one; the counter tops out at 15.
    localparam int CW         = 4;
    localparam int EFF_CYCLES = (ACCESS_CYCLES < 1)  ? 1 :
                                (ACCESS_CYCLES > 15) ? 15 : ACCESS_CYCLES;
    localparam logic [CW-1:0] CNT_LOAD = CW'(EFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          any_req;
    logic          win;
    req_t          sel;

    assign any_req = p0_req | p1_req;

    // On a tie the port that did not win last time goes next.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        win = 1'b0;
        if (p0_req && p1_req) begin
            win = ~grant;
        end else if (p1_req) begin
            win = 1'b1;
        end
        sel = win ? {p1_we, p1_addr, p1_wdata} : {p0_we, p0_addr, p0_wdata};
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cnt       <= '0;
            grant     <= 1'b1;
            busy      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_d     <= '0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            // NOTE: the read-data holding registers are plain flops, not RAM, so they take the reset value too.
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant     <= win;
                        mem_addr  <= sel.addr;
                        mem_d     <= sel.wdata;
                        mem_write <= sel.we;
                        mem_read  <= ~sel.we;
                        cnt       <= CNT_LOAD;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (mem_read) begin
                            if (grant) begin
                                p1_rdata <= mem_q;
                            end else begin
                                p0_rdata <= mem_q;
                            end
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    // Requests are not re-evaluated here; the ack lands as the FSM returns to IDLE.
                    p0_ack <= ~grant;
                    p1_ack <= grant;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    strobes_exclusive: assert property (@(posedge clk) disable iff (!clr) !(mem_read && mem_write));
    acks_exclusive:    assert property (@(posedge clk) disable iff (!clr) !(p0_ack && p1_ack));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: one instance with single-cycle access and RAM model,
// one with three-cycle access backed by a read-only memory image.
module tb_ram_port_arbiter;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [8:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_d, mem_q;
    logic        busy, grant;

    logic        b_clr, b_p0_req, b_p0_ack, b_p1_ack;
    logic [8:0]  b_p0_addr, b_mem_addr;
    logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_d, b_mem_q;
    logic        b_mem_read, b_mem_write, b_busy, b_grant;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [8:0] a);
        case (a)
            9'h001:  return 32'h11111111;
            9'h002:  return 32'h22222222;
            9'h005:  return 32'h05050505;
            9'h010:  return 32'hDEADBEEF;
            9'h020:  return 32'h20202020;
            9'h030:  return 32'h30303030;
            9'h040:  return 32'h40404040;
            default: return {23'h2A5A5A, a};
        endcase
    endfunction

    logic [31:0] ram [512];
    bit          ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_val(9'(i));
            ram_ready <= 1'b1;
        end else if (mem_write) begin
            ram[mem_addr] <= mem_d;
        end
    end

    assign mem_q   = mem_read   ? ram[mem_addr]        : 'z;
    assign b_mem_q = b_mem_read ? init_val(b_mem_addr) : 'z;

    ram_port_arbiter #(.AW(9), .DW(32), .ACCESS_CYCLES(1)) dut (
        .clk(clk), .clr(clr),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_d(mem_d),
        .mem_q(mem_q), .busy(busy), .grant(grant)
    );

    ram_port_arbiter #(.AW(9), .DW(32), .ACCESS_CYCLES(3)) dut_b (
        .clk(clk), .clr(b_clr),
        .p0_req(b_p0_req), .p0_we(1'b0), .p0_addr(b_p0_addr), .p0_wdata(32'h0),
        .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
        .p1_req(1'b0), .p1_we(1'b0), .p1_addr(9'h0), .p1_wdata(32'h0),
        .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr), .mem_d(b_mem_d),
        .mem_q(b_mem_q), .busy(b_busy), .grant(b_grant)
    );

    // Stimulus-only helper: watches one access on the main instance until the given port is acked.
    task automatic run_until_ack(input bit port, input logic [8:0] addr, output int cyc,
                                 output int rd, output int wr, output bit overlap,
                                 output bit addr_ok, output bit acked);
        cyc = 0; rd = 0; wr = 0; overlap = 0; addr_ok = 1; acked = 0;
        while (!acked && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_read) rd++;
            if (mem_write) wr++;
            if (mem_read && mem_write) overlap = 1;
            if ((mem_read || mem_write) && mem_addr !== addr) addr_ok = 0;
            acked = port ? p1_ack : p0_ack;
        end
    endtask

    task automatic test_reset();
        clr = 1'b0; b_clr = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        b_p0_req = 0; b_p0_addr = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_read, mem_write, p0_ack, p1_ack, busy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {mem_read, mem_write, p0_ack, p1_ack, busy});
        end
        n_checks++;
        if (mem_addr !== 9'h0 || mem_d !== 32'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got addr=%h d=%h want 0/0", mem_addr, mem_d);
        end
        n_checks++;
        if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", p0_rdata, p1_rdata);
        end
        n_checks++;
        if (grant !== 1'b1 || b_grant !== 1'b1) begin
            n_fail++; $display("FAIL reset_grant: got %b/%b want 1/1", grant, b_grant);
        end
        clr = 1'b1; b_clr = 1'b1;
    endtask

    task automatic test_p0_read();
        int cyc, rd, wr; bit ov, aok, acked; exp_t e;
        @(negedge clk);
        p0_we = 0; p0_addr = 9'h010; p0_wdata = '0; p0_req = 1;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        run_until_ack(1'b0, 9'h010, cyc, rd, wr, ov, aok, acked);
        p0_req = 0;
        n_checks++;
        if (!acked) begin
            n_fail++; $display("FAIL p0_read_timeout: got no ack after %0d cycles want ack", cyc);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (p0_rdata !== e.data) begin
                n_fail++; $display("FAIL p0_read_data: got %h want %h", p0_rdata, e.data);
            end
        end
        n_checks++;
        if (cyc !== 3) begin
            n_fail++; $display("FAIL p0_read_latency: got %0d want 3", cyc);
        end
        n_checks++;
        if (rd !== 1 || wr !== 0 || !aok) begin
            n_fail++; $display("FAIL p0_read_strobes: got rd=%0d wr=%0d addr_ok=%0d want 1/0/1", rd, wr, aok);
        end
        n_checks++;
        if (p1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL p0_read_p1_untouched: got %h want 0", p1_rdata);
        end
        @(negedge clk);
        n_checks++;
        if (p0_ack !== 1'b0) begin
            n_fail++; $display("FAIL p0_ack_pulse: got %b want 0", p0_ack);
        end
    endtask

    task automatic test_p1_write_read();
        int cyc, rd, wr; bit ov, aok, acked; exp_t e;
        @(negedge clk);
        p1_we = 1; p1_addr = 9'h1FF; p1_wdata = 32'h12345678; p1_req = 1;
        sb.push_back('{1'b1, 32'h0});
        run_until_ack(1'b1, 9'h1FF, cyc, rd, wr, ov, aok, acked);
        p1_req = 0;
        n_checks++;
        if (!acked || cyc !== 3) begin
            n_fail++; $display("FAIL p1_write_ack: got acked=%0d cyc=%0d want 1/3", acked, cyc);
        end
        n_checks++;
        if (wr !== 1 || rd !== 0 || ov || !aok) begin
            n_fail++; $display("FAIL p1_write_strobes: got wr=%0d rd=%0d ov=%0d aok=%0d want 1/0/0/1", wr, rd, ov, aok);
        end
        e = sb.pop_front();
        n_checks++;
        if (p1_rdata !== e.data || p0_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL p1_write_rdata_hold: got %h/%h want %h/deadbeef", p1_rdata, p0_rdata, e.data);
        end
        @(negedge clk);
        p1_we = 0; p1_wdata = '0; p1_req = 1;
        sb.push_back('{1'b1, 32'h12345678});
        run_until_ack(1'b1, 9'h1FF, cyc, rd, wr, ov, aok, acked);
        p1_req = 0;
        e = sb.pop_front();
        n_checks++;
        if (!acked || p1_rdata !== e.data) begin
            n_fail++; $display("FAIL p1_readback: got acked=%0d data=%h want 1/%h", acked, p1_rdata, e.data);
        end
        n_checks++;
        if (rd !== 1 || wr !== 0 || ov) begin
            n_fail++; $display("FAIL p1_read_strobes: got rd=%0d wr=%0d ov=%0d want 1/0/0", rd, wr, ov);
        end
    endtask

    task automatic test_round_robin();
        int cyc, last, nack; exp_t e; bit port;
        @(negedge clk); clr = 0;
        @(negedge clk); clr = 1;
        p0_we = 0; p0_addr = 9'h001; p0_req = 1;
        p1_we = 0; p1_addr = 9'h002; p1_req = 1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{1'b0, 32'h11111111});
            sb.push_back('{1'b1, 32'h22222222});
        end
        cyc = 0; last = 0; nack = 0;
        while (nack < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (p0_ack || p1_ack) begin
                port = p1_ack;
                e = sb.pop_front();
                n_checks++;
                if (port !== e.port || grant !== e.port || (p0_ack && p1_ack)) begin
                    n_fail++; $display("FAIL rr_order: ack %0d got port=%0d grant=%0d want %0d", nack, port, grant, e.port);
                end
                n_checks++;
                if ((port ? p1_rdata : p0_rdata) !== e.data) begin
                    n_fail++; $display("FAIL rr_data: ack %0d got %h want %h", nack, port ? p1_rdata : p0_rdata, e.data);
                end
                n_checks++;
                if (cyc - last !== 3) begin
                    n_fail++; $display("FAIL rr_spacing: ack %0d got %0d cycles want 3", nack, cyc - last);
                end
                last = cyc;
                nack++;
            end
        end
        p0_req = 0; p1_req = 0;
        n_checks++;
        if (nack !== 4) begin
            n_fail++; $display("FAIL rr_timeout: got %0d acks want 4", nack);
        end
    endtask

    task automatic test_reset_mid_access();
        int cyc, nack, stray; exp_t e;
        @(negedge clk);
        p1_we = 1; p1_addr = 9'h020; p1_wdata = 32'h0000AAAA; p1_req = 1;
        @(negedge clk);
        n_checks++;
        if (mem_write !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_setup: got mem_write=%b want 1", mem_write);
        end
        clr = 0;
        #1;
        n_checks++;
        if ({mem_read, mem_write, busy} !== 3'b0) begin
            n_fail++; $display("FAIL mid_reset_async: got %b want 000", {mem_read, mem_write, busy});
        end
        p1_req = 0; p1_we = 0; p1_wdata = '0;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (p0_ack || p1_ack) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++; $display("FAIL mid_reset_no_ack: got %0d acks want 0", stray);
        end
        clr = 1;
        p0_we = 0; p0_addr = 9'h020; p0_req = 1;
        p1_addr = 9'h002; p1_req = 1;
        sb.push_back('{1'b0, 32'h20202020});
        sb.push_back('{1'b1, 32'h22222222});
        cyc = 0; nack = 0;
        while (nack < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (p0_ack || p1_ack) begin
                e = sb.pop_front();
                n_checks++;
                if (p1_ack !== e.port || (e.port ? p1_rdata : p0_rdata) !== e.data) begin
                    n_fail++; $display("FAIL mid_reset_after: ack %0d got port=%0d data=%h want %0d/%h",
                                       nack, p1_ack, p1_ack ? p1_rdata : p0_rdata, e.port, e.data);
                end
                if (p0_ack) p0_req = 0;
                if (p1_ack) p1_req = 0;
                nack++;
            end
        end
        p0_req = 0; p1_req = 0;
        n_checks++;
        if (nack !== 2) begin
            n_fail++; $display("FAIL mid_reset_timeout: got %0d acks want 2", nack);
        end
    endtask

    task automatic test_addr_change();
        int cyc, rd, wr; bit ov, aok, acked; exp_t e;
        @(negedge clk);
        p0_we = 0; p0_addr = 9'h030; p0_req = 1;
        sb.push_back('{1'b0, 32'h30303030});
        @(negedge clk);
        p0_addr = 9'h040;
        n_checks++;
        if (mem_addr !== 9'h030 || mem_read !== 1'b1) begin
            n_fail++; $display("FAIL addr_latch: got addr=%h rd=%b want 030/1", mem_addr, mem_read);
        end
        run_until_ack(1'b0, 9'h030, cyc, rd, wr, ov, aok, acked);
        p0_req = 0;
        e = sb.pop_front();
        n_checks++;
        if (!acked || !aok || p0_rdata !== e.data) begin
            n_fail++; $display("FAIL addr_change_data: got acked=%0d aok=%0d data=%h want 1/1/%h", acked, aok, p0_rdata, e.data);
        end
        n_checks++;
        if (p1_rdata !== 32'h22222222) begin
            n_fail++; $display("FAIL addr_change_p1_hold: got %h want 22222222", p1_rdata);
        end
    endtask

    task automatic test_access_cycles3();
        int cyc, rd, bsy; bit acked; exp_t e;
        @(negedge clk);
        b_p0_addr = 9'h005; b_p0_req = 1;
        sb.push_back('{1'b0, 32'h05050505});
        cyc = 0; rd = 0; bsy = 0; acked = 0;
        while (!acked && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (b_mem_read) rd++;
            if (b_busy) bsy++;
            acked = b_p0_ack;
        end
        b_p0_req = 0;
        e = sb.pop_front();
        n_checks++;
        if (!acked || cyc !== 5) begin
            n_fail++; $display("FAIL ac3_latency: got acked=%0d cyc=%0d want 1/5", acked, cyc);
        end
        n_checks++;
        if (rd !== 3 || bsy !== 4) begin
            n_fail++; $display("FAIL ac3_strobe_busy: got rd=%0d busy=%0d want 3/4", rd, bsy);
        end
        n_checks++;
        if (b_p0_rdata !== e.data || b_p1_rdata !== 32'h0 || b_p1_ack !== 1'b0) begin
            n_fail++; $display("FAIL ac3_data: got %h/%h/%b want %h/0/0", b_p0_rdata, b_p1_rdata, b_p1_ack, e.data);
        end
        n_checks++;
        if (b_mem_write !== 1'b0 || b_grant !== 1'b0 || b_mem_d !== 32'h0) begin
            n_fail++; $display("FAIL ac3_misc: got wr=%b grant=%b d=%h want 0/0/0", b_mem_write, b_grant, b_mem_d);
        end
    endtask

    initial begin
        test_reset();
        test_p0_read();
        test_p1_write_read();
        test_round_robin();
        test_reset_mid_access();
        test_addr_change();
        test_access_cycles3();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the 512 x 32 main-memory RAM.
- Port 0 is the instruction-fetch side; port 1 is the load/store (MDR/MAR) side.
- Grants one request at a time with round-robin fairness, drives the RAM's address, read, write and data inputs, and captures read data into a per-port holding register.
- Returns a one-cycle ack to the granted requester.

Parameters:
- AW, 9, address width; RAM depth is 2^AW words.
- DW, 32, data word width.
- ACCESS_CYCLES, 1, cycles the RAM strobes are held per access; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  reset, asynchronous, active-low.
- p0_req  input  1  port 0 request; held high until p0_ack.
- p0_we  input  1  port 0 write enable; 1 = write, 0 = read.
- p0_addr  input  AW  port 0 word address.
- p0_wdata  input  DW  port 0 write data.
- p0_ack  output  1  port 0 completion pulse, one cycle.
- p0_rdata  output  DW  port 0 read data; valid while p0_ack is high and held afterwards.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1.
- mem_read  output  1  to RAM read.
- mem_write  output  1  to RAM write.
- mem_addr  output  AW  to RAM MARout.
- mem_d  output  DW  to RAM D.
- mem_q  input  DW  from RAM Q; combinational, Z when not reading.
- busy  output  1  high in ACCESS and RESP.
- grant  output  1  index of the current or most recent granted port.

Behaviour:
- Reset (clr low, asynchronous):
  - State goes to IDLE.
  - mem_read, mem_write, p0_ack, p1_ack and busy go to 0.
  - mem_addr, mem_d, p0_rdata and p1_rdata go to 0.
  - grant goes to 1, so port 0 wins the first tie.
  - Wait counter goes to 0.
- State machine, three states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One port requesting: grant it.
  - Both requesting: grant the port that is not `grant`.
  - On the grant edge: latch the winner's addr, we and wdata into mem_addr, mem_write/mem_read and mem_d; update `grant`; load counter with ACCESS_CYCLES-1; go to ACCESS.
- ACCESS:
  - mem_read = !we and mem_write = we, held steady for ACCESS_CYCLES cycles; mem_addr and mem_d are stable for the whole access.
  - Counter decrements each cycle. On the edge where it equals 0:
    - Read: mem_q is captured into the granted port's rdata.
    - Both strobes drop to 0; go to RESP.
  - Writes commit on every ACCESS edge, which is idempotent because address and data are the same.
- RESP:
  - The granted port's ack = 1 for exactly one cycle; go to IDLE.
  - A new arbitration is not evaluated in RESP; a requester must drop req in the cycle after ack.
- Latency: req seen high at edge k leads to ack high during the cycle after edge k+ACCESS_CYCLES+1.
  - With ACCESS_CYCLES=1, ack rises 2 cycles after the sampling edge.
- Throughput: one access per ACCESS_CYCLES+2 cycles.
- mem_read and mem_write are never high together. Both are 0 in IDLE and RESP, so the RAM Q bus is Z there.
- rdata of the non-granted port never changes. A write access does not alter either rdata.
- Request inputs changing during ACCESS/RESP are ignored, because the address and data were latched at grant.
- Reset mid-ACCESS:
  - Strobes clear immediately and no ack is issued.
  - If clr falls before the clk edge, the pending write is not committed.
- Out-of-range ACCESS_CYCLES (0) is illegal; the implementation must treat it as 1.

Test Plan:
- Reset, then p0 read addr 0x010, where RAM[0x010]=0xDEADBEEF -> mem_read high for 1 cycle with mem_addr=0x010; p0_ack pulses 2 cycles after request; p0_rdata=0xDEADBEEF; p1_rdata stays 0.
- p1 write addr 0x1FF data 0x12345678, then p1 read 0x1FF -> mem_write high for 1 cycle only, never together with mem_read; read returns 0x12345678; wrap-top address is handled.
- p0 and p1 request continuously from reset (reads of 0x001 and 0x002) -> grant sequence 0,1,0,1; each ack arrives every 3 cycles; there is no starvation.
- ACCESS_CYCLES=3, p0 read 0x005 -> mem_read high for exactly 3 cycles; ack 4 cycles after the sampling edge; busy high for 4 cycles.
- clr asserted in the ACCESS cycle of a p1 write of 0x0000AAAA to 0x020 -> strobes drop asynchronously; no ack; RAM[0x020] unchanged; next request is granted to port 0.
- p0 changes p0_addr from 0x030 to 0x040 during ACCESS -> mem_addr stays 0x030; rdata returns RAM[0x030].
